ror_sched: RTL and testbench
============================

Name: ror_sched

Overview:
- Scheduler and sequencer for the shared 4-bit rotate-right unit `ror` (input_bits, k1, k2, output_bits; rotate amount = {k1,k2}, 0..3).
- Arbitrates round-robin between two requesters, each asking for a 4-bit word rotated right by an arbitrary count.
- Drives the external `ror` instance one step (max 3 positions) per cycle, feeding back its output until the count is exhausted.
- Returns the result on a valid/ready response port, tagged with the requester id.

Parameters:
AMT_W, 8, width of the requested rotate amount (max amount 2^AMT_W-1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a request
req0_ready  output  1  request 0 accepted this cycle
req0_data  input  4  word to rotate, requester 0
req0_amt  input  AMT_W  rotate-right count, requester 0
req1_valid  input  1  requester 1 has a request
req1_ready  output  1  request 1 accepted this cycle
req1_data  input  4  word to rotate, requester 1
req1_amt  input  AMT_W  rotate-right count, requester 1
ror_in  output  4  to ror.input_bits
ror_k1  output  1  to ror.k1 (MSB of step)
ror_k2  output  1  to ror.k2 (LSB of step)
ror_out  input  4  from ror.output_bits (combinational)
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_data  output  4  rotated word
rsp_id  output  1  requester id of result (0/1)
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE; work, rem, id, rr_ptr = 0; outputs rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, ror_in=0, ror_k1=ror_k2=0.
- Reset wins over every other event, including mid-RUN or DONE; in-flight request is dropped, no response is issued.
- FSM states IDLE, RUN, DONE.
- Grant, combinational in IDLE only:
  - grant0 = req0_valid & (!req1_valid | rr_ptr==0).
  - grant1 = req1_valid & (!req0_valid | rr_ptr==1).
  - reqN_ready = (state==IDLE) & grantN.
  - Both readys are 0 outside IDLE.
- IDLE accept (valid&ready):
  - Latch work=data, rem=amt, id=N.
  - rem==0 -> DONE; else -> RUN.
- RUN, one step per cycle:
  - step = min(rem,3); ror_in=work; {ror_k1,ror_k2}=step.
  - Clock edge: work<=ror_out; rem<=rem-step.
  - If rem-step==0 -> DONE.
  - RUN occupancy = ceil(amt/3) cycles.
- Outside RUN: ror_in=work, {ror_k1,ror_k2}=00 (no rotation).
- DONE:
  - rsp_valid=1, rsp_data=work, rsp_id=id; held stable until rsp_ready.
  - On rsp_valid&rsp_ready: -> IDLE; rr_ptr <= ~id, so the other requester gets priority next.
- Latency, accept to rsp_valid: 1 cycle for amt=0; otherwise ceil(amt/3)+1 cycles.
- Accepting the next request in the same cycle as the response handshake is not allowed; IDLE always lasts at least one cycle.
- Max amount 2^AMT_W-1 must complete without wrap or underflow; rem never goes negative.

Optional Feature:
- Macro ROR_SCHED_FAST_MOD_EN.
- Defined: at accept, rem is latched as amt mod 4 (amt[1:0]), so RUN lasts at most 1 cycle and latency is ≤2 cycles. Results are identical.
- Undefined: full iterative stepping exactly as above.

Test Plan:
- req0: data=0101, amt=1 -> ror_k={0,1} for 1 RUN cycle; rsp_data=1010, rsp_id=0, rsp_valid 2 cycles after accept.
- req1: data=0001, amt=5 -> steps 3 then 2 (2 RUN cycles); rsp_data=1000, rsp_id=1, rsp_valid 3 cycles after accept.
- req0 and req1 both valid continuously after reset, amt=0 -> grant order 0,1,0,1; each response equals its input word; rsp_valid 1 cycle after accept.
- req0: data=0011, amt=255 (AMT_W=8) -> 85 RUN cycles; rsp_data=0110. With ROR_SCHED_FAST_MOD_EN: 1 RUN cycle, same result.
- rsp_ready held low 5 cycles in DONE -> rsp_data/rsp_id stable, both reqN_ready=0, busy=1.
- rst asserted in the 2nd RUN cycle of amt=9 -> next cycle: state IDLE, busy=0, rsp_valid=0, no response; rr_ptr=0.

Source files
------------

// File: rtl/ror_sched.sv
// ror_sched: round-robin scheduler that drives a shared 4-bit rotate-right unit, up to 3 positions per cycle.
// Define ROR_SCHED_FAST_MOD_EN to latch only amt mod 4 at accept, so each job takes at most one RUN cycle.
module ror_sched #(
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_data,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_data,
    input  logic [AMT_W-1:0] req1_amt,
    output logic [3:0]       ror_in,
    output logic             ror_k1,
    output logic             ror_k2,
    input  logic [3:0]       ror_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic             rsp_id,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [3:0]       work_q;
    logic [AMT_W-1:0] rem_q, rem_d, amt_d;
    logic             id_q, rr_q, grant0, grant1;
    logic [1:0]       step;

    always_comb begin
        grant0 = req0_valid & (!req1_valid | !rr_q);
        grant1 = req1_valid & (!req0_valid | rr_q);
        step   = (rem_q > AMT_W'(3)) ? 2'd3 : rem_q[1:0];
        rem_d  = rem_q - AMT_W'(step);
`ifdef ROR_SCHED_FAST_MOD_EN
        // A full turn of a 4-bit word is the identity, so only amt mod 4 matters.
        amt_d  = (grant1 ? req1_amt : req0_amt) & AMT_W'(3);
`else
        amt_d  = grant1 ? req1_amt : req0_amt;
`endif
    end

    assign req0_ready         = (state_q == IDLE) & grant0;
    assign req1_ready         = (state_q == IDLE) & grant1;
    assign ror_in             = work_q;
    assign {ror_k1, ror_k2}   = (state_q == RUN) ? step : 2'b00;
    assign rsp_valid          = state_q == DONE;
    assign rsp_data           = work_q;
    assign rsp_id             = id_q;
    assign busy               = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (grant0 | grant1) begin
                    work_q  <= grant1 ? req1_data : req0_data;
                    rem_q   <= amt_d;
                    id_q    <= grant1;
                    state_q <= (amt_d == '0) ? DONE : RUN;
                end
                RUN: begin
                    work_q <= ror_out;
                    rem_q  <= rem_d;
                    if (rem_d == '0) state_q <= DONE;
                end
                DONE: if (rsp_ready) begin
                    state_q <= IDLE;
                    rr_q    <= ~id_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ror_sched.sv
// tb_ror_sched: directed plus randomized checks of ror_sched against a transaction-level model,
// with the external rotate-right unit modelled combinationally.
module tb_ror_sched;
    logic       clk = 0, rst = 1;
    logic       req0_valid = 0, req1_valid = 0, rsp_ready = 0;
    logic [3:0] req0_data = 0, req1_data = 0;
    logic [7:0] req0_amt = 0, req1_amt = 0;
    logic       req0_ready, req1_ready, ror_k1, ror_k2, rsp_valid, rsp_id, busy;
    logic [3:0] ror_in, ror_out, rsp_data;
    int         n_cmp = 0, n_bad = 0;
    logic       prio_m = 0;

    ror_sched #(.AMT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
        .ror_in(ror_in), .ror_k1(ror_k1), .ror_k2(ror_k2), .ror_out(ror_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rotr(input logic [3:0] x, input int s);
        logic [7:0] t;
        t = {x, x} >> (s % 4);
        return t[3:0];
    endfunction

    assign ror_out = rotr(ror_in, int'({ror_k1, ror_k2}));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
        prio_m = 0;
    endtask

    // One full transaction: grant, stepping, response (optionally stalled), handshake.
    task automatic xact(input logic v0, input logic v1, input logic [3:0] d0, input logic [3:0] d1,
                        input logic [7:0] a0, input logic [7:0] a1, input int stall, input bit keep);
        logic       g;
        logic [3:0] ed;
        int         ea, rem_m, lat, exp_lat, stp;
        g  = (v0 && v1) ? prio_m : v1;
        ed = g ? d1 : d0;
        ea = g ? int'(a1) : int'(a0);
        req0_valid = v0; req1_valid = v1;
        req0_data = d0; req1_data = d1; req0_amt = a0; req1_amt = a1;
        #1;
        check("req0_ready_grant", req0_ready, !g);
        check("req1_ready_grant", req1_ready, g);
        tick();
        if (!keep) begin req0_valid = 0; req1_valid = 0; end
`ifdef ROR_SCHED_FAST_MOD_EN
        rem_m = ea % 4;
`else
        rem_m = ea;
`endif
        exp_lat = (rem_m == 0) ? 1 : (rem_m + 2) / 3 + 1;
        lat = 1;
        while (!rsp_valid && lat < 400) begin
            stp = (rem_m > 3) ? 3 : rem_m;
            check("ror_step", {ror_k1, ror_k2}, stp);
            rem_m -= (stp == 0) ? 0 : stp;
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, rotr(ed, ea));
        check("rsp_id", rsp_id, g);
        check("busy_done", busy, 1);
        for (int s = 0; s < stall; s++) begin
            req0_valid = 1; req1_valid = 1;
            #1;
            check("stall_req0_ready", req0_ready, 0);
            check("stall_req1_ready", req1_ready, 0);
            check("stall_rsp_data", rsp_data, rotr(ed, ea));
            check("stall_rsp_id", rsp_id, g);
            check("stall_busy", busy, 1);
            tick();
        end
        if (stall > 0 && !keep) begin req0_valid = 0; req1_valid = 0; end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_busy", busy, 0);
        prio_m = ~g;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v0, v1;
        logic [7:0] a0, a1;
        tick();
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_ror_in", ror_in, 0);
        check("rst_ror_k", {ror_k1, ror_k2}, 0);
        check("rst_readys", {req0_ready, req1_ready}, 0);

        xact(1, 0, 4'b0101, 4'b0000, 8'd1, 8'd0, 0, 0);
        xact(0, 1, 4'b0000, 4'b0001, 8'd0, 8'd5, 0, 0);

        do_reset();
        for (int i = 0; i < 4; i++)
            xact(1, 1, 4'($urandom), 4'($urandom), 8'd0, 8'd0, 0, 1);
        req0_valid = 0; req1_valid = 0;

        xact(1, 0, 4'b0011, 4'b0000, 8'd255, 8'd0, 5, 0);

        // Reset in the second RUN cycle of an amt=9 job from requester 0.
        req0_valid = 1; req0_data = 4'b1001; req0_amt = 8'd9;
        tick();
        req0_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        prio_m = 0;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_rsp_valid", rsp_valid, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        check("midrun_rst_rr0", req0_ready, 1);
        check("midrun_rst_rr1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        tick();
        check("midrun_no_rsp", rsp_valid, 0);

        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1;
            a0 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255) : 8'($urandom);
            a1 = 8'($urandom);
            xact(v0, v1, 4'($urandom), 4'($urandom), a0, a1, $urandom_range(0, 3), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
